// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding, word-length codes, divisors.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int unsigned DIV_OSM0 = 16;
  localparam int unsigned DIV_OSM1 = 13;

  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       stb;
    logic       osm;
  } tx_cfg_t;

  function automatic logic [2:0] last_bit(
    input logic [1:0] wls
  );
    case (wls)
      WLS_5:   return 3'd4;
      WLS_6:   return 3'd5;
      WLS_7:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Parity over only the bits that go on the wire.
  function automatic logic tx_parity(
    input logic [7:0] d,
    input logic [1:0] wls,
    input logic       eps
  );
    logic [7:0] m;
    case (wls)
      WLS_5:   m = 8'h1F;
      WLS_6:   m = 8'h3F;
      WLS_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return (^(d & m)) ^ ~eps;
  endfunction

endpackage

// File: rtl/tx_tick_gen.sv
// Bit-period divider: counts qualified baud pulses, 16 or 13 per bit.
// Emits a one-clk tick on the last pulse of each bit period.
module tx_tick_gen
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_osm,
  output logic o_tick
);

  logic [3:0] r_cnt;
  logic [3:0] w_last;

  assign w_last = i_osm ? 4'(DIV_OSM1 - 1)
                        : 4'(DIV_OSM0 - 1);

  assign o_tick = i_en && !i_clr &&
                  (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_en) begin
      r_cnt <= o_tick ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FSM, shifter and parity around tx_tick_gen.
// Frame settings are latched on acceptance.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_clk,
  input  logic       BGE,
  input  logic       OSM_SEL,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       STB,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       UART_TX_O
);

  logic [2:0] r_state;
  tx_cfg_t    r_cfg;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_stopcnt;
  logic       r_parity;
  logic       r_tx;
  logic       r_done;

  logic w_accept;
  logic w_tick;

  assign tx_ready  = (r_state == ST_IDLE);
  assign tx_busy   = (r_state != ST_IDLE);
  assign tx_done   = r_done;
  assign UART_TX_O = r_tx;
  assign w_accept  = tx_valid && tx_ready;

  tx_tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (baud_clk & BGE),
    .i_osm  (r_cfg.osm),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cfg     <= '0;
      r_shift   <= 8'd0;
      r_bitcnt  <= 3'd0;
      r_stopcnt <= 1'b0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift   <= tx_data;
            r_cfg.wls <= WLS;
            r_cfg.pen <= PEN;
            r_cfg.stb <= STB;
            r_cfg.osm <= OSM_SEL;
            r_parity  <= tx_parity(tx_data, WLS, EPS);
            r_bitcnt  <= 3'd0;
            r_stopcnt <= 1'b0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bitcnt == last_bit(r_cfg.wls)) begin
              r_bitcnt <= 3'd0;
              if (r_cfg.pen) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx      <= 1'b1;
            r_stopcnt <= 1'b0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_cfg.stb && !r_stopcnt) begin
              r_stopcnt <= 1'b1;
            end else begin
              r_stopcnt <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected frames
// consumed by a line monitor that counts qualified baud pulses.
module tb_uart_tx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       baud_clk = 1'b0;
  logic       BGE      = 1'b1;
  logic       OSM_SEL  = 1'b0;
  logic [1:0] WLS      = 2'b11;
  logic       PEN      = 1'b0;
  logic       EPS      = 1'b0;
  logic       STB      = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       UART_TX_O;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_clk  (baud_clk),
    .BGE       (BGE),
    .OSM_SEL   (OSM_SEL),
    .WLS       (WLS),
    .PEN       (PEN),
    .EPS       (EPS),
    .STB       (STB),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .UART_TX_O (UART_TX_O)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          div;
  } frame_t;

  frame_t sb[$];
  int start_cyc[$];
  int done_cyc[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_seen = 0;
  int baud_period = 1;
  int bcnt = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bcnt >= baud_period - 1) begin
      bcnt = 0;
      baud_clk = 1'b1;
    end else begin
      bcnt++;
      baud_clk = 1'b0;
    end
  end

  function automatic frame_t mk(
    input logic [7:0] d, input logic [1:0] w,
    input logic pen, input logic eps,
    input logic stb, input logic osm
  );
    frame_t f;
    int nd;
    logic p;
    nd = 5 + int'(w);
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.n = 1;
    p = ~eps;
    for (int i = 0; i < nd; i++) begin
      f.bits[f.n] = d[i];
      p ^= d[i];
      f.n++;
    end
    if (pen) begin
      f.bits[f.n] = p;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (stb) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    f.div = osm ? 13 : 16;
    return f;
  endfunction

  // Line monitor: checks bit boundaries and mid-bit values by pulse count.
  initial begin : mon
    logic prev;
    logic pe;
    frame_t f;
    int p;
    int tot;
    int idx;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && prev && !UART_TX_O) begin
        start_cyc.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start cyc=%0d", cyc);
        end else begin
          if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL start_flags rdy=%b busy=%b exp 0/1",
                     tx_ready, tx_busy);
          end
          f = sb.pop_front();
          p = 0;
          tot = f.n * f.div;
          while (p < tot) begin
            @(posedge clk);
            pe = baud_clk & BGE;
            #1;
            if (pe) begin
              p++;
              idx = p / f.div;
              if (p < tot) begin
                if ((p % f.div) == 0 ||
                    (p % f.div) == f.div / 2 ||
                    (p % f.div) == f.div - 1) begin
                  total++;
                  if (UART_TX_O !== f.bits[idx]) begin
                    bad++;
                    $display("FAIL line bit=%0d pulse=%0d got=%b exp=%b",
                             idx, p, UART_TX_O, f.bits[idx]);
                  end
                end
                total++;
                if (tx_done !== 1'b0 || tx_busy !== 1'b1 ||
                    tx_ready !== 1'b0) begin
                  bad++;
                  $display("FAIL mid_flags pulse=%0d done=%b busy=%b rdy=%b exp 0/1/0",
                           p, tx_done, tx_busy, tx_ready);
                end
              end
            end
          end
          total++;
          if (tx_done !== 1'b1 || tx_ready !== 1'b1 ||
              tx_busy !== 1'b0 || UART_TX_O !== 1'b1) begin
            bad++;
            $display("FAIL end_flags done=%b rdy=%b busy=%b line=%b exp 1/1/0/1",
                     tx_done, tx_ready, tx_busy, UART_TX_O);
          end
          done_cyc.push_back(cyc);
          frames_seen++;
        end
      end
      prev = UART_TX_O;
    end
  end

  task automatic send(
    input logic [7:0] d, input logic [1:0] w,
    input logic pen, input logic eps,
    input logic stb, input logic osm,
    input bit push, input bit hold
  );
    int k;
    @(negedge clk);
    tx_data = d;
    WLS = w;
    PEN = pen;
    EPS = eps;
    STB = stb;
    OSM_SEL = osm;
    tx_valid = 1'b1;
    if (push) sb.push_back(mk(d, w, pen, eps, stb, osm));
    k = 0;
    while (tx_ready !== 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 20000) begin
      bad++;
      $display("FAIL accept_timeout got=%0d max=%0d", k, 20000);
    end
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    tx_data = ~d;
    WLS = ~w;
    PEN = ~pen;
    EPS = ~eps;
    STB = ~stb;
    OSM_SEL = ~osm;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (frames_seen < n) begin
      bad++;
      $display("FAIL frame_timeout seen=%0d want=%0d", frames_seen, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (UART_TX_O !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset line=%b busy=%b done=%b exp 1/0/0",
               UART_TX_O, tx_busy, tx_done);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || UART_TX_O !== 1'b1) begin
      bad++;
      $display("FAIL post_reset rdy=%b line=%b exp 1/1", tx_ready, UART_TX_O);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_8n1();
    int n;
    int len;
    n = frames_seen;
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_frames(n + 1, 400);
    len = done_cyc[done_cyc.size() - 1] - start_cyc[start_cyc.size() - 1];
    total++;
    if (len !== 160) begin
      bad++;
      $display("FAIL frame_len_8n1 got=%0d exp=%0d", len, 160);
    end
  endtask

  task automatic test_5e2();
    int n;
    n = frames_seen;
    send(8'hE7, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_frames(n + 1, 400);
  endtask

  task automatic test_osm13();
    int n;
    n = frames_seen;
    baud_period = 3;
    send(8'h01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_frames(n + 1, 1000);
    baud_period = 1;
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    n = frames_seen;
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_frames(n + 2, 800);
    gap = start_cyc[start_cyc.size() - 1] - done_cyc[done_cyc.size() - 2];
    total++;
    if (gap !== 1) begin
      bad++;
      $display("FAIL b2b_gap got=%0d exp=%0d", gap, 1);
    end
  endtask

  task automatic test_bge_stall();
    int n;
    int len;
    n = frames_seen;
    send(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (70) @(negedge clk);
    BGE = 1'b0;
    repeat (40) @(negedge clk);
    BGE = 1'b1;
    wait_frames(n + 1, 600);
    len = done_cyc[done_cyc.size() - 1] - start_cyc[start_cyc.size() - 1];
    total++;
    if (len !== 200) begin
      bad++;
      $display("FAIL stall_len got=%0d exp=%0d", len, 200);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mon_en = 1'b0;
    send(8'h5A, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (150) @(negedge clk);
    total++;
    if (tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort busy=%b exp=1", tx_busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (UART_TX_O !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort line=%b done=%b busy=%b exp 1/0/0",
               UART_TX_O, tx_done, tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    n = frames_seen;
    mon_en = 1'b1;
    tx_data = 8'h0F;
    WLS = 2'b11;
    PEN = 1'b0;
    EPS = 1'b0;
    STB = 1'b0;
    OSM_SEL = 1'b0;
    tx_valid = 1'b1;
    sb.push_back(mk(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    total++;
    if (UART_TX_O !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL restart line=%b busy=%b done=%b exp 0/1/0",
               UART_TX_O, tx_busy, tx_done);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_frames(n + 1, 400);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5e2();
    test_osm13();
    test_back_to_back();
    test_bge_stall();
    test_reset_mid();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 baud_clk  input  1  one-clk-wide baud enable pulse from the shared baud generator.
REQ-005 BGE  input  1  baud generator enable; baud_clk is ignored while BGE=0.
REQ-006 OSM_SEL  input  1  oversampling mode: 0 = 16 baud_clk pulses per bit, 1 = 13 baud_clk pulses per bit.
REQ-007 WLS  input  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 PEN  input  1  parity enable.
REQ-009 EPS  input  1  even parity select: 1 = even, 0 = odd.
REQ-010 STB  input  1  stop bits: 0 = one, 1 = two.
REQ-011 tx_valid  input  1  tx_data holds a character to send.
REQ-012 tx_data  input  8  character; transmitted LSB first, bits above the WLS length ignored.
REQ-013 tx_ready  output  1  block accepts a character this cycle.
REQ-014 tx_busy  output  1  a frame is in progress.
REQ-015 tx_done  output  1  one-clk pulse at frame completion.
REQ-016 UART_TX_O  output  1  serial line, idle high; registered output.

Function
REQ-017 Handshake: a character SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE.
REQ-018 On acceptance, tx_data, WLS, PEN, EPS, STB and OSM_SEL SHALL be latched; changes to these inputs mid-frame SHALL not affect the current frame.
REQ-019 FSM states: IDLE -> START -> DATA -> PARITY (only if PEN=1) -> STOP -> IDLE.
REQ-020 UART_TX_O SHALL go low on the first clk after acceptance (START), so latency from acceptance to start edge is 1 clk.
REQ-021 Tick generation: a tick counter SHALL advance only on cycles where baud_clk & BGE = 1; the bit period SHALL be exactly 16 (OSM_SEL=0) or 13 (OSM_SEL=1) such pulses.
REQ-022 The tick counter SHALL be cleared on entry to START, so every bit, including the start bit, has the full period.
REQ-023 DATA SHALL shift out 5-8 bits per the latched WLS; the bit counter SHALL wrap to 0 on leaving DATA.
REQ-024 The parity bit SHALL be the XOR of the transmitted data bits when EPS=1, and its inverse when EPS=0.
REQ-025 STOP SHALL drive 1 for one bit period (STB=0) or two bit periods (STB=1).
REQ-026 At the end of the final stop-bit period, tx_done SHALL pulse for 1 clk in the same cycle the FSM enters IDLE, and tx_ready SHALL be 1 from that cycle.
REQ-027 Back-to-back frames: tx_valid held high SHALL start the next frame with no idle bit in between; the start bit follows the last stop bit by 1 clk.
REQ-028 BGE=0 mid-frame SHALL freeze the tick and bit counters and hold UART_TX_O; transmission resumes when BGE returns to 1.
REQ-029 tx_busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 While rst=1: state=IDLE, all counters=0, UART_TX_O=1, tx_ready=1 after release, tx_busy=0, tx_done=0.
REQ-031 rst asserted mid-frame SHALL abort the frame; UART_TX_O=1 on the next clk and no tx_done pulse is produced.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state encoding, WLS encodings, and the divisor constants (16, 13); the receive path shall use the same package.
REQ-033 One sub-module, tx_tick_gen (divides baud_clk&BGE by 16/13, synchronous clear, one-clk tick out), SHALL be instantiated; the FSM, shifter and parity logic stay in uart_tx.

Verification
REQ-034 WLS=11, PEN=0, STB=0, OSM_SEL=0, baud_clk every clk, tx_data=0x55 -> line carries 0,1,0,1,0,1,0,1,0,1, each bit 16 clks; tx_done 160 clks after the start edge.
REQ-035 WLS=00, PEN=1, EPS=1, STB=1, tx_data=0xE7 (5-bit value 00111) -> 0,1,1,1,0,0, parity 1, stop 1,1; bits 5-7 are not sent.
REQ-036 OSM_SEL=1, EPS=0, PEN=1, WLS=11, tx_data=0x01 -> each bit lasts 13 baud pulses; parity bit 0.
REQ-037 tx_valid held high with data 0xA5 then 0x3C -> second start bit 1 clk after the first frame's tx_done; tx_ready is high only on that cycle.
REQ-038 BGE=0 for 40 clks during data bit 3 -> bit 3 is stretched by 40 clks, no bit is lost, and the frame is otherwise correct.
REQ-039 rst pulsed during the parity bit -> UART_TX_O=1 on the next clk, tx_done never pulses, and a new frame is accepted on the first clk after release.
